// File: rtl/axis_requant_packer_pkg.sv
// axis_requant_pkg: shared widths, packer states and the per-lane requant rule.
package axis_requant_pkg;
  localparam int LANES = 16;
  localparam int PROD_WIDTH = 16;
  localparam int OUT_WIDTH = 8;
  localparam logic [3:0] SHIFT_MAX = 4'd8;
  typedef enum logic [1:0] {EMPTY, HALF, FLUSH} pack_state_e;
  function automatic logic [3:0] clamp_shift(input logic [3:0] s);
    return (s > SHIFT_MAX) ? SHIFT_MAX : s;
  endfunction
  // Returns {sat_flag, y}; the 17-bit sum cannot overflow for any 16-bit product.
  function automatic logic [OUT_WIDTH:0] requant_lane(input logic signed [PROD_WIDTH-1:0] p,
                                                      input logic [3:0] s);
    logic signed [PROD_WIDTH:0] t;
    logic sat;
    t = {p[PROD_WIDTH-1], p};
    t = (s == 4'd0) ? t : ((t + (17'sd1 <<< (s - 4'd1))) >>> s);
    sat = (t > 17'sd127) || (t < -17'sd128);
    return {sat, sat ? (t[PROD_WIDTH] ? 8'h80 : 8'h7f) : t[OUT_WIDTH-1:0]};
  endfunction
endpackage

// File: rtl/axis_requant_packer_if.sv
// axis_requant_packer_if: AXI-Stream bundle, data/keep widths set per instance.
interface axis_requant_packer_if #(
  parameter int DW = 256,
  parameter int KW = 32
);
  logic [DW-1:0] tdata;
  logic [KW-1:0] tkeep;
  logic          tvalid;
  logic          tlast;
  logic          tready;
  modport master (output tdata, tkeep, tvalid, tlast, input tready);
  modport slave  (input tdata, tkeep, tvalid, tlast, output tready);
endinterface

// File: rtl/axis_requant_packer_lanes.sv
// requant_lane_array: combinational 16-lane requant with keep masking and saturated-lane popcount.
module requant_lane_array
  import axis_requant_pkg::*;
(
  input  logic [LANES*PROD_WIDTH-1:0] data_i,
  input  logic [LANES-1:0]            keep_i,
  input  logic [3:0]                  shift_i,
  output logic [LANES*OUT_WIDTH-1:0]  y_o,
  output logic [4:0]                  sat_cnt_o
);
  logic [LANES-1:0] sat;
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [OUT_WIDTH:0] r;
    assign r = requant_lane(data_i[i*PROD_WIDTH +: PROD_WIDTH], shift_i);
    assign y_o[i*OUT_WIDTH +: OUT_WIDTH] = keep_i[i] ? r[OUT_WIDTH-1:0] : '0;
    assign sat[i] = keep_i[i] & r[OUT_WIDTH];
  end
  always_comb begin
    sat_cnt_o = '0;
    for (int i = 0; i < LANES; i++) sat_cnt_o = sat_cnt_o + 5'(sat[i]);
  end
endmodule

// File: rtl/axis_requant_packer.sv
// axis_requant_packer: requantizes product beats to int8 and packs beat pairs into 256-bit S2MM words.
module axis_requant_packer
  import axis_requant_pkg::*;
(
  input  logic                  CLK,
  input  logic                  reset,
  axis_requant_packer_if.slave  s_axis,
  axis_requant_packer_if.master m_axis_s2mm,
  input  logic [3:0]            shift_amt,
  input  logic                  sat_clear,
  output logic [31:0]           sat_count
);
  localparam int HW = LANES * OUT_WIDTH;
  logic                 s1_valid_q, s1_last_q, in_pkt_q;
  logic [HW-1:0]        s1_data_q, lo_data_q, rq_y;
  logic [LANES-1:0]     s1_keep_q, lo_keep_q;
  logic [3:0]           shift_q, s_eff;
  pack_state_e          state_q, state_d;
  logic                 m_valid_q, m_last_q, m_last_d;
  logic [2*HW-1:0]      m_data_q, m_data_d;
  logic [2*LANES-1:0]   m_keep_q, m_keep_d;
  logic [31:0]          sat_count_q;
  logic [32:0]          sat_sum;
  logic [4:0]           rq_sat;
  logic                 in_hs, out_can, out_load, s1_adv;
  // The shift is frozen for the remainder of a packet once its first beat is taken.
  assign s_eff = in_pkt_q ? shift_q : clamp_shift(shift_amt);
  requant_lane_array u_lanes (
    .data_i    (s_axis.tdata),
    .keep_i    (s_axis.tkeep),
    .shift_i   (s_eff),
    .y_o       (rq_y),
    .sat_cnt_o (rq_sat)
  );
  assign out_can       = !m_valid_q || m_axis_s2mm.tready;
  assign s_axis.tready = !reset && (!s1_valid_q || s1_adv);
  assign in_hs         = s_axis.tvalid && s_axis.tready;
  assign sat_sum       = {1'b0, sat_count_q} + {28'd0, in_hs ? rq_sat : 5'd0};
  // A lone tlast beat goes straight out when the output register is free; FLUSH only parks it otherwise.
  always_comb begin
    state_d  = state_q;
    s1_adv   = 1'b0;
    out_load = 1'b0;
    m_data_d = {{HW{1'b0}}, lo_data_q};
    m_keep_d = {{LANES{1'b0}}, lo_keep_q};
    m_last_d = 1'b1;
    case (state_q)
      EMPTY: if (s1_valid_q) begin
        s1_adv   = 1'b1;
        out_load = s1_last_q && out_can;
        m_data_d = {{HW{1'b0}}, s1_data_q};
        m_keep_d = {{LANES{1'b0}}, s1_keep_q};
        state_d  = !s1_last_q ? HALF : out_can ? EMPTY : FLUSH;
      end
      HALF: if (s1_valid_q && out_can) begin
        s1_adv   = 1'b1;
        out_load = 1'b1;
        m_data_d = {s1_data_q, lo_data_q};
        m_keep_d = {s1_keep_q, lo_keep_q};
        m_last_d = s1_last_q;
        state_d  = EMPTY;
      end
      FLUSH: if (out_can) begin
        out_load = 1'b1;
        state_d  = EMPTY;
      end
      default: state_d = EMPTY;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      s1_data_q   <= '0;
      s1_keep_q   <= '0;
      s1_last_q   <= 1'b0;
      in_pkt_q    <= 1'b0;
      shift_q     <= '0;
      state_q     <= EMPTY;
      lo_data_q   <= '0;
      lo_keep_q   <= '0;
      m_valid_q   <= 1'b0;
      m_data_q    <= '0;
      m_keep_q    <= '0;
      m_last_q    <= 1'b0;
      sat_count_q <= '0;
    end else begin
      state_q <= state_d;
      if (s_axis.tready) s1_valid_q <= s_axis.tvalid;
      if (in_hs) begin
        s1_data_q <= rq_y;
        s1_keep_q <= s_axis.tkeep;
        s1_last_q <= s_axis.tlast;
        in_pkt_q  <= !s_axis.tlast;
        if (!in_pkt_q) shift_q <= s_eff;
      end
      if (state_q == EMPTY && s1_adv) begin
        lo_data_q <= s1_data_q;
        lo_keep_q <= s1_keep_q;
      end
      if (out_load) begin
        m_valid_q <= 1'b1;
        m_data_q  <= m_data_d;
        m_keep_q  <= m_keep_d;
        m_last_q  <= m_last_d;
      end else if (m_axis_s2mm.tready) begin
        m_valid_q <= 1'b0;
      end
      sat_count_q <= sat_clear ? '0 : sat_sum[32] ? '1 : sat_sum[31:0];
    end
  end
  assign m_axis_s2mm.tvalid = m_valid_q;
  assign m_axis_s2mm.tdata  = m_data_q;
  assign m_axis_s2mm.tkeep  = m_keep_q;
  assign m_axis_s2mm.tlast  = m_last_q;
  assign sat_count          = sat_count_q;
endmodule
